// File: rtl/md_unit.sv
// Multiply/divide unit for the MIPS execute stage: owns HI/LO, runs MULT/MULTU/DIV/DIVU
// with a fixed busy latency, and applies MTHI/MTLO in a single cycle.
module md_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] p_hi, p_hi_nx;
  logic [31:0] p_lo, p_lo_nx;
  logic [31:0] hi_nx, lo_nx;

  logic [63:0] prod_s, prod_u;
  logic        div_signed, neg_a, neg_b;
  logic [31:0] mag_a, mag_b, divisor, uq, ur, quot, rem;

  // Results are computed in full at issue; the busy window only models pipeline latency.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed division via magnitudes avoids the INT_MIN / -1 overflow trap of native signed divide.
  assign div_signed = (md_op == OP_DIV);
  assign neg_a      = div_signed & a[31];
  assign neg_b      = div_signed & b[31];
  assign mag_a      = neg_a ? (32'd0 - a) : a;
  assign mag_b      = neg_b ? (32'd0 - b) : b;
  assign divisor    = (b == 32'd0) ? 32'd1 : mag_b;
  assign uq         = mag_a / divisor;
  assign ur         = mag_a % divisor;
  assign quot       = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
  assign rem        = neg_a ? (32'd0 - ur) : ur;

  assign busy      = (state == RUN);
  assign stall_req = busy | (start & (md_op <= OP_DIVU));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    p_hi_nx  = p_hi;
    p_lo_nx  = p_lo;
    hi_nx    = hi;
    lo_nx    = lo;
    unique case (state)
      IDLE: begin
        if (start) begin
          unique case (md_op)
            OP_MULT: begin
              p_hi_nx  = prod_s[63:32];
              p_lo_nx  = prod_s[31:0];
              cnt_nx   = MUL_CNT;
              state_nx = RUN;
            end
            OP_MULTU: begin
              p_hi_nx  = prod_u[63:32];
              p_lo_nx  = prod_u[31:0];
              cnt_nx   = MUL_CNT;
              state_nx = RUN;
            end
            OP_DIV, OP_DIVU: begin
              // A zero divisor latches the current HI/LO so completion rewrites them unchanged.
              if (b == 32'd0) begin
                p_hi_nx = hi;
                p_lo_nx = lo;
              end else begin
                p_hi_nx = rem;
                p_lo_nx = quot;
              end
              cnt_nx   = DIV_CNT;
              state_nx = RUN;
            end
            OP_MTHI: hi_nx = a;
            OP_MTLO: lo_nx = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          hi_nx    = p_hi;
          lo_nx    = p_lo;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      p_hi  <= 32'd0;
      p_lo  <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      p_hi  <= p_hi_nx;
      p_lo  <= p_lo_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
    end
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the execute stage of the 5-stage MIPS pipeline. It executes MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency, owns the HI/LO registers, and serves MTHI/MTLO writes and MFHI/MFLO reads. Its `busy` and `stall_req` outputs drive the pipeline hazard controller, which stalls D-stage mult/div/HI/LO instructions while the unit is occupied.

## Interface
- `MUL_CYCLES`, default 5: busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU (≥1).

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- `start`  in  1  E-stage instruction is an MD op this cycle.
- `md_op`  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved (no-op).
- `a`  in  32  rs operand, already forwarded.
- `b`  in  32  rt operand, already forwarded.
- `busy`  out  1  mult/div in progress.
- `stall_req`  out  1  `busy | (start & md_op<=3)`, combinational; consumed by the hazard controller.
- `hi`  out  32  HI register, registered; used by MFHI.
- `lo`  out  32  LO register, registered; used by MFLO.

## Operation
- States: IDLE (`busy`=0) and RUN (`busy`=1); 4-bit down-counter `cnt`; 32-bit pending registers `p_hi` and `p_lo`.
- IDLE with `start`=1:
  - ops 0–3: compute the full result, latch it into `p_hi`/`p_lo`, load `cnt` with MUL_CYCLES or DIV_CYCLES, go to RUN.
  - op 4: `hi`<=`a`. Op 5: `lo`<=`a`. Both take effect in one cycle; state stays IDLE.
  - ops 6–7: nothing changes.
- RUN: `cnt` decrements each edge. On the edge where `cnt`==1, `hi`<=`p_hi`, `lo`<=`p_lo`, and the unit returns to IDLE.
- `start` during RUN is ignored. The controller guarantees it never happens. The bench checks that it has no effect.
- MULT: signed 32×32→64. MULTU: unsigned. In both, `hi`=product[63:32] and `lo`=product[31:0].
- DIV/DIVU: `lo`=quotient, `hi`=remainder. Signed division truncates toward zero, and the remainder takes the sign of the dividend.
- Divisor 0: the unit still runs DIV_CYCLES busy cycles. HI and LO stay unchanged at completion.
- Reset (`reset`=0, any time, including mid-RUN):
  - `hi`=0, `lo`=0, `busy`=0, `cnt`=0, `p_hi`/`p_lo`=0, state IDLE.
  - Any pending result is discarded.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `stall_req`=`start & md_op<=3`.
- Mult/div accepted at edge k:
  - `busy`=1 during cycles k+1 … k+N, where N is MUL_CYCLES or DIV_CYCLES.
  - New `hi`/`lo` are visible from cycle k+N+1, the same cycle `busy` falls.
- MTHI/MTLO at edge k: new value visible in cycle k+1.
- No internal bypass. An MFHI in E in the cycle right after an MTHI reads the new value, because it is registered at edge k.
- Back-to-back: a new mult/div may start in the first cycle `busy`=0.

## Test plan
- Reset, then MULT with `a`=0xFFFFFFFD, `b`=5 → `busy` high for exactly 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- MULTU with `a`=0xFFFFFFFF, `b`=2 → `hi`=0x00000001, `lo`=0xFFFFFFFE after 5 busy cycles.
- DIV with `a`=0xFFFFFFF9 (−7), `b`=2 → 10 busy cycles; `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- MTHI with `a`=0x12345678 → `hi`=0x12345678 next cycle, `busy` stays 0. Then DIVU with `a`=7, `b`=0 → 10 busy cycles, `hi` still 0x12345678 afterwards.
- During a DIV busy window, pulse `start` with MTLO `a`=0xAAAA5555 → `lo` unchanged by it, the busy count is unaffected, and the final DIV result lands on schedule.
- Assert `reset`=0 asynchronously at busy cycle 3 of a MULT → `busy`=0, `hi`=`lo`=0 immediately, without waiting for a clock edge. After release, no late write of the aborted result occurs.
